// File: rtl/alu_pkg.sv
// Definitions shared between the ALU and its response queue: pipeline latency,
// result word type and the width helper for occupancy counters.
package alu_pkg;

    localparam int ALU_LAT   = 2;
    localparam int DEF_DEPTH = 4;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t data;
    } alu_resp_t;

    // Width needed to hold an occupancy value 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int CNT_W = cnt_w(DEF_DEPTH);

endpackage

// File: rtl/alu_resp_queue_if.sv
// ALU-side and consumer-side signals of the response queue. The queue itself
// takes the slave view; the issuer/ALU/consumer environment takes the master view.
interface alu_resp_queue_if
    import alu_pkg::*;
#(
    parameter int WIDTH = $bits(word_t),
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CW = cnt_w(DEPTH);

    logic             issue;
    logic [WIDTH-1:0] alu_f;
    logic             alu_valid;
    logic             can_issue;
    logic [WIDTH-1:0] resp_data;
    logic             resp_valid;
    logic             resp_ready;
    logic             err;
    logic [CW-1:0]    count;

    modport master (
        output issue, alu_f, alu_valid, resp_ready,
        input  can_issue, resp_data, resp_valid, err, count
    );

    modport slave (
        input  issue, alu_f, alu_valid, resp_ready,
        output can_issue, resp_data, resp_valid, err, count
    );

endinterface

// File: rtl/alu_resp_fifo.sv
// Result storage for the ALU response queue: circular buffer with explicit
// pointer wrap, so any DEPTH >= 2 works. Storage contents are never reset.
module alu_resp_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [cnt_w(DEPTH)-1:0]    count_o
);
    localparam int CW = cnt_w(DEPTH);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en, rd_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        empty_o  = (count_q == '0);
        full_o   = (count_q == CW'(DEPTH));
        rd_en    = pop_i && !empty_o;
        // A full queue still accepts a write when the head leaves the same cycle.
        wr_en    = push_i && (!full_o || rd_en);
        wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = rd_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CW'(wr_en) - CW'(rd_en);
        rdata_o  = mem_q[rd_ptr_q];
        count_o  = count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/alu_resp_queue.sv
// Buffers every result of the non-stallable ALU and hands out issue credits so
// that queued plus in-flight results never exceed the storage.
module alu_resp_queue
    import alu_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ALU_LAT = alu_pkg::ALU_LAT,
    parameter int WIDTH   = 32
) (
    input  logic         clk,
    input  logic         rst,
    alu_resp_queue_if.slave q
);
    localparam int CW = cnt_w(DEPTH);
    localparam int BW = $clog2(ALU_LAT + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [CW-1:0]    inflight_q, inflight_d;
    logic [BW-1:0]    blank_q, blank_d;
    logic             err_q, err_d;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rdata;
    logic             full, empty;
    logic             live, push, pop, issue_acc, can_issue, inflight_dec;

    alu_resp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (q.alu_f),
        .pop_i   (pop),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        // Unreset ALU pipeline registers may hold garbage until ALU_LAT cycles pass.
        live         = (blank_q == '0);
        push         = live && q.alu_valid;
        pop          = !empty && q.resp_ready;
        can_issue    = live && (({1'b0, count} + {1'b0, inflight_q}) < DEPTH_C);
        issue_acc    = q.issue && can_issue;
        inflight_dec = push && (inflight_q != '0);
        blank_d      = live ? blank_q : blank_q - BW'(1);
        inflight_d   = inflight_q + CW'(issue_acc) - CW'(inflight_dec);
        err_d        = err_q
                     | (q.issue && !can_issue)
                     | (push && full && !pop)
                     | (push && (inflight_q == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
            blank_q    <= BW'(ALU_LAT);
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            blank_q    <= blank_d;
            err_q      <= err_d;
        end
    end

    assign q.can_issue  = can_issue;
    assign q.resp_valid = !empty;
    assign q.resp_data  = rdata;
    assign q.err        = err_q;
    assign q.count      = count;

endmodule

// File: tb/tb_alu_resp_queue.sv
// Directed bench for alu_resp_queue: a 2-stage ALU model feeds results, a
// scoreboard queue holds expected responses and a monitor checks each pop.
module tb_alu_resp_queue;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_resp_queue_if #(.WIDTH(32), .DEPTH(4)) q ();

    alu_resp_queue #(.DEPTH(4), .ALU_LAT(2), .WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .q   (q)
    );

    // ALU model: result of the op issued in cycle N appears in cycle N+2.
    word_t op_d    = '0;
    logic  p0_v    = 1'b0;
    logic  p1_v    = 1'b0;
    word_t p0_d    = '0;
    word_t p1_d    = '0;
    logic  force_v = 1'b0;
    word_t force_f = '0;

    always @(posedge clk) begin
        p0_v <= q.issue;
        p0_d <= op_d;
        p1_v <= p0_v;
        p1_d <= p0_d;
    end

    assign q.alu_valid = p1_v | force_v;
    assign q.alu_f     = force_v ? force_f : p1_d;

    word_t sb[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        q.issue      = 1'b0;
        q.resp_ready = 1'b0;
        force_v      = 1'b0;
        sb.delete();
        step();
        rst = 1'b0;
    endtask

    // Monitor: every completed handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && q.resp_valid && q.resp_ready) begin
            if (sb.size() == 0) chk("pop_unexpected", q.resp_data, 32'hxxxx_xxxx);
            else                chk("resp_data", q.resp_data, sb.pop_front());
        end
        if (!rst && !q.err)
            chk("credit_invariant", 32'(({1'b0, q.count} + {1'b0, dut.inflight_q}) <= 4'd4), 32'd1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        q.issue      = 1'b0;
        q.resp_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Blank window: credit withheld, stray result ignored.
        chk("rst_can_issue", 32'(q.can_issue), 32'd0);
        chk("rst_resp_valid", 32'(q.resp_valid), 32'd0);
        chk("rst_count", 32'(q.count), 32'd0);
        chk("rst_err", 32'(q.err), 32'd0);
        force_v = 1'b1;
        force_f = 32'hDEAD;
        step();
        force_v = 1'b0;
        chk("blank1_can_issue", 32'(q.can_issue), 32'd0);
        chk("blank1_count", 32'(q.count), 32'd0);
        step();
        chk("blank_done_can_issue", 32'(q.can_issue), 32'd1);
        chk("stray_ignored_count", 32'(q.count), 32'd0);
        chk("stray_ignored_err", 32'(q.err), 32'd0);

        // Single op: result visible one cycle after alu_valid.
        q.resp_ready = 1'b1;
        q.issue = 1'b1;
        op_d    = 32'h0000_0005;
        if (q.can_issue) sb.push_back(op_d);
        step();
        q.issue = 1'b0;
        step();
        chk("lat_not_yet_valid", 32'(q.resp_valid), 32'd0);
        step();
        chk("lat_valid", 32'(q.resp_valid), 32'd1);
        chk("lat_data", q.resp_data, 32'h5);
        step();
        chk("single_count", 32'(q.count), 32'd0);

        // Credit-limited burst with the consumer stalled.
        q.resp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            q.issue = q.can_issue;
            op_d    = 32'(acc + 1);
            if (q.can_issue) begin
                sb.push_back(op_d);
                acc++;
            end
            step();
        end
        q.issue = 1'b0;
        chk("burst_accepted", 32'(acc), 32'd4);
        chk("burst_count", 32'(q.count), 32'd4);
        chk("burst_can_issue", 32'(q.can_issue), 32'd0);
        chk("burst_err", 32'(q.err), 32'd0);

        // Full queue, push and pop together. With the queue full nothing can be
        // in flight, so this result is unsolicited and raises err.
        force_v      = 1'b1;
        force_f      = 32'hA5A5_A5A5;
        q.resp_ready = 1'b1;
        sb.push_back(force_f);
        step();
        force_v = 1'b0;
        chk("full_pushpop_count", 32'(q.count), 32'd4);
        chk("full_pushpop_err", 32'(q.err), 32'd1);
        repeat (4) step();
        chk("drain_count", 32'(q.count), 32'd0);
        chk("drain_resp_valid", 32'(q.resp_valid), 32'd0);
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);

        // Issue without credit (inside the blank window).
        do_reset();
        chk("reset_clears_err", 32'(q.err), 32'd0);
        q.issue = 1'b1;
        op_d    = 32'h77;
        step();
        q.issue = 1'b0;
        chk("bad_issue_err", 32'(q.err), 32'd1);
        chk("bad_issue_inflight", 32'(dut.inflight_q), 32'd0);
        repeat (4) step();
        chk("err_sticky", 32'(q.err), 32'd1);

        // Reset with three results queued and two still inside the ALU.
        do_reset();
        step();
        step();
        q.resp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            q.issue = 1'b1;
            op_d    = 32'(11 + i);
            step();
        end
        q.issue = 1'b0;
        chk("pre_reset_count", 32'(q.count), 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_reset_count", 32'(q.count), 32'd0);
        chk("mid_reset_resp_valid", 32'(q.resp_valid), 32'd0);
        chk("mid_reset_err", 32'(q.err), 32'd0);
        chk("mid_reset_can_issue", 32'(q.can_issue), 32'd0);
        repeat (3) step();
        chk("post_blank_count", 32'(q.count), 32'd0);
        chk("post_blank_resp_valid", 32'(q.resp_valid), 32'd0);
        chk("post_blank_err", 32'(q.err), 32'd0);
        chk("post_blank_can_issue", 32'(q.can_issue), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
